// File: rtl/hazard_ctrl_if.sv
// Decode-stage hazard bundle: D-instruction operand/producer info toward the controller,
// stall and forwarding selects back to the datapath.
interface hazard_ctrl_if;
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [2:0] D_Tuse_rs;
  logic [2:0] D_Tuse_rt;
  logic       D_RegWrite;
  logic [4:0] D_A3;
  logic [2:0] D_Tnew;
  logic [1:0] D_md_op;
  logic       D_md_use;
  logic       stall;
  logic [1:0] fwd_D_rs;
  logic [1:0] fwd_D_rt;
  logic [1:0] fwd_E_rs;
  logic [1:0] fwd_E_rt;
  logic [1:0] fwd_M_rt;
  logic       md_busy;

  modport master (
    output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_RegWrite, D_A3, D_Tnew, D_md_op, D_md_use,
    input  stall, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt, md_busy
  );

  modport slave (
    input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_RegWrite, D_A3, D_Tnew, D_md_op, D_md_use,
    output stall, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt, md_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Tuse/Tnew hazard unit for a 5-stage pipeline: stall and forward selects are combinational
// from shadow E/M/W records; stall freezes D and bubbles E, the mult/div counter blocks HI/LO users.
module hazard_ctrl (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a3;
    logic       regwrite;
    logic [2:0] tnew;
  } stage_t;

  stage_t     r_e;
  stage_t     r_m;
  stage_t     r_w;
  logic [1:0] r_e_md_op;
  logic [3:0] r_md_cnt;

  stage_t     w_d_rec;
  logic       w_stall;
  logic       w_unused;

  function automatic logic produces(input stage_t s, input logic [4:0] r);
    return s.regwrite && (s.a3 == r) && (r != 5'd0);
  endfunction

  function automatic stage_t age(input stage_t s);
    stage_t a;
    a = s;
    if (s.tnew != 3'd0) a.tnew = s.tnew - 3'd1;
    return a;
  endfunction

  function automatic logic late(input logic [4:0] r, input logic [2:0] tuse,
                                input stage_t e, input stage_t m);
    return (tuse != 3'd5) &&
           ((produces(e, r) && (e.tnew > tuse)) || (produces(m, r) && (m.tnew > tuse)));
  endfunction

  // Nearest producer decides; one still computing (Tnew!=0) hides older results.
  function automatic logic [1:0] pick(input logic [4:0] r, input stage_t e, input stage_t m,
                                      input stage_t w, input logic use_e, input logic use_m);
    if (use_e && produces(e, r)) return (e.tnew == 3'd0) ? 2'd1 : 2'd0;
    if (use_m && produces(m, r)) return (m.tnew == 3'd0) ? 2'd2 : 2'd0;
    if (produces(w, r) && (w.tnew == 3'd0)) return 2'd3;
    return 2'd0;
  endfunction

  assign w_d_rec = '{rs: hz.D_rs, rt: hz.D_rt, a3: hz.D_A3,
                     regwrite: hz.D_RegWrite, tnew: hz.D_Tnew};

  assign w_stall = late(hz.D_rs, hz.D_Tuse_rs, r_e, r_m)
                 | late(hz.D_rt, hz.D_Tuse_rt, r_e, r_m)
                 | (hz.D_md_use && ((r_md_cnt != 4'd0) || (r_e_md_op != 2'd0)));

  assign hz.stall    = reset & w_stall;
  assign hz.md_busy  = reset & (r_md_cnt != 4'd0);
  assign hz.fwd_D_rs = reset ? pick(hz.D_rs, r_e, r_m, r_w, 1'b1, 1'b1) : 2'd0;
  assign hz.fwd_D_rt = reset ? pick(hz.D_rt, r_e, r_m, r_w, 1'b1, 1'b1) : 2'd0;
  assign hz.fwd_E_rs = reset ? pick(r_e.rs,  r_e, r_m, r_w, 1'b0, 1'b1) : 2'd0;
  assign hz.fwd_E_rt = reset ? pick(r_e.rt,  r_e, r_m, r_w, 1'b0, 1'b1) : 2'd0;
  assign hz.fwd_M_rt = reset ? pick(r_m.rt,  r_e, r_m, r_w, 1'b0, 1'b0) : 2'd0;

  // Kept for pipeline visibility, no hazard path reads them.
  assign w_unused = ^{r_m.rs, r_w.rs, r_w.rt};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_e       <= '0;
      r_m       <= '0;
      r_w       <= '0;
      r_e_md_op <= 2'd0;
      r_md_cnt  <= 4'd0;
    end else begin
      if (w_stall) begin
        r_e       <= '0;
        r_e_md_op <= 2'd0;
      end else begin
        r_e       <= w_d_rec;
        r_e_md_op <= hz.D_md_op;
      end
      r_m <= age(r_e);
      r_w <= age(r_m);
      case (r_e_md_op)
        2'd1:    r_md_cnt <= 4'd5;
        2'd2:    r_md_cnt <= 4'd10;
        default: if (r_md_cnt != 4'd0) r_md_cnt <= r_md_cnt - 4'd1;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table of pipeline scenarios, directed mult/div and reset sequences,
// then random traffic against a queue-style reference model.
module tb_hazard_ctrl;
  logic clk;
  logic reset;

  hazard_ctrl_if hif ();

  hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs;
    logic [2:0] tur;
    logic [4:0] rt;
    logic [2:0] tut;
    logic       rw;
    logic [4:0] a3;
    logic [2:0] tnew;
    logic [1:0] mdop;
    logic       use_md;
  } din_t;

  typedef struct {
    logic       stall;
    logic [1:0] fdrs;
    logic [1:0] fdrt;
    logic [1:0] fers;
    logic [1:0] fert;
    logic [1:0] fmrt;
    logic       busy;
  } dout_t;

  typedef struct {
    logic  rst;
    din_t  d;
    dout_t e;
  } vec_t;

  typedef struct {
    int rs;
    int rt;
    int a3;
    int rw;
    int tnew;
    int mdop;
  } mrec_t;

  int    checks = 0;
  int    errors = 0;
  vec_t  vq[$];
  din_t  cur_d;
  logic  cur_rst;
  mrec_t pipe[3];
  int    md_cnt;

  function automatic din_t mk(int rs, int tur, int rt, int tut, int rw, int a3, int tnew,
                              int mdop, int use_md);
    din_t d;
    d.rs = 5'(rs);  d.tur = 3'(tur);   d.rt = 5'(rt);     d.tut = 3'(tut);
    d.rw = 1'(rw);  d.a3 = 5'(a3);     d.tnew = 3'(tnew); d.mdop = 2'(mdop);
    d.use_md = 1'(use_md);
    return d;
  endfunction

  function automatic dout_t ex(int st, int fdrs, int fdrt, int fers, int fert, int fmrt, int busy);
    dout_t o;
    o.stall = 1'(st);   o.fdrs = 2'(fdrs); o.fdrt = 2'(fdrt); o.fers = 2'(fers);
    o.fert = 2'(fert);  o.fmrt = 2'(fmrt); o.busy = 1'(busy);
    return o;
  endfunction

  function automatic void add(logic rst, din_t d, dout_t e);
    vec_t v;
    v.rst = rst; v.d = d; v.e = e;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input dout_t e);
    chk({tag, ".stall"},    int'(hif.stall),    int'(e.stall));
    chk({tag, ".fwd_D_rs"}, int'(hif.fwd_D_rs), int'(e.fdrs));
    chk({tag, ".fwd_D_rt"}, int'(hif.fwd_D_rt), int'(e.fdrt));
    chk({tag, ".fwd_E_rs"}, int'(hif.fwd_E_rs), int'(e.fers));
    chk({tag, ".fwd_E_rt"}, int'(hif.fwd_E_rt), int'(e.fert));
    chk({tag, ".fwd_M_rt"}, int'(hif.fwd_M_rt), int'(e.fmrt));
    chk({tag, ".md_busy"},  int'(hif.md_busy),  int'(e.busy));
  endtask

  // ---------------- reference model: pipe[0]=E, pipe[1]=M, pipe[2]=W ----------------
  function automatic bit m_prod(int k, int r);
    return (pipe[k].rw != 0) && (pipe[k].a3 == r) && (r != 0);
  endfunction

  function automatic int m_fwd(int r, int first);
    for (int k = first; k < 3; k++)
      if (m_prod(k, r)) return (pipe[k].tnew == 0) ? k + 1 : 0;
    return 0;
  endfunction

  function automatic bit m_late(int r, int tuse);
    if (tuse == 5) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (m_prod(k, r) && (pipe[k].tnew > tuse)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic dout_t m_expect();
    dout_t o;
    o = ex(0, 0, 0, 0, 0, 0, 0);
    if (cur_rst) begin
      o.stall = m_late(int'(cur_d.rs), int'(cur_d.tur)) || m_late(int'(cur_d.rt), int'(cur_d.tut)) ||
                (cur_d.use_md && (md_cnt != 0 || pipe[0].mdop != 0));
      o.fdrs  = 2'(m_fwd(int'(cur_d.rs), 0));
      o.fdrt  = 2'(m_fwd(int'(cur_d.rt), 0));
      o.fers  = 2'(m_fwd(pipe[0].rs, 1));
      o.fert  = 2'(m_fwd(pipe[0].rt, 1));
      o.fmrt  = 2'(m_fwd(pipe[1].rt, 2));
      o.busy  = (md_cnt != 0);
    end
    return o;
  endfunction

  function automatic mrec_t m_age(mrec_t r);
    mrec_t a;
    a = r;
    a.tnew = (r.tnew > 0) ? r.tnew - 1 : 0;
    return a;
  endfunction

  function automatic void m_step();
    dout_t o;
    o = m_expect();
    if (!cur_rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
      md_cnt = 0;
    end else begin
      if (pipe[0].mdop == 1)      md_cnt = 5;
      else if (pipe[0].mdop == 2) md_cnt = 10;
      else if (md_cnt > 0)        md_cnt = md_cnt - 1;
      pipe[2] = m_age(pipe[1]);
      pipe[1] = m_age(pipe[0]);
      if (o.stall) pipe[0] = '{default: 0};
      else pipe[0] = '{rs: int'(cur_d.rs), rt: int'(cur_d.rt), a3: int'(cur_d.a3),
                       rw: int'(cur_d.rw), tnew: int'(cur_d.tnew), mdop: int'(cur_d.mdop)};
    end
  endfunction

  task automatic put(input logic rst, input din_t d);
    reset          = rst;
    hif.D_rs       = d.rs;   hif.D_Tuse_rs  = d.tur;
    hif.D_rt       = d.rt;   hif.D_Tuse_rt  = d.tut;
    hif.D_RegWrite = d.rw;   hif.D_A3       = d.a3;
    hif.D_Tnew     = d.tnew; hif.D_md_op    = d.mdop;
    hif.D_md_use   = d.use_md;
    cur_rst = rst;
    cur_d   = d;
  endtask

  task automatic drive(input logic rst, input din_t d);
    @(negedge clk);
    put(rst, d);
    #1;
  endtask

  task automatic advance();
    m_step();
    @(posedge clk);
  endtask

  initial begin
    din_t  nop, mflo, d;
    dout_t z;
    int    n_stall, n_busy;
    int    tu[4];
    tu  = '{0, 1, 2, 5};
    nop = mk(0, 5, 0, 5, 0, 0, 0, 0, 0);
    z   = ex(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
    md_cnt = 0;
    put(1'b0, nop);

    //   rst  rs tur rt tut rw a3 tnew mdop use        st fdrs fdrt fers fert fmrt busy
    add(0, mk( 2, 0, 3, 0, 0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 0, 0)); // reset masks D
    add(1, mk(29, 1, 2, 5, 1, 2, 2, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)); // lw $2
    add(1, mk( 2, 1, 5, 1, 1, 4, 1, 0, 0), ex(1, 0, 0, 0, 0, 0, 0)); // addu $4,$2: load-use
    add(1, mk( 2, 1, 5, 1, 1, 4, 1, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)); // lw in M, Tnew==Tuse
    add(1, nop,                            ex(0, 0, 0, 3, 0, 0, 0)); // addu in E gets W
    add(1, mk( 1, 1, 1, 1, 1, 3, 1, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)); // addu $3
    add(1, mk( 3, 0, 4, 0, 0, 0, 0, 0, 0), ex(1, 0, 3, 0, 0, 0, 0)); // beq $3,$4
    add(1, mk( 3, 0, 4, 0, 0, 0, 0, 0, 0), ex(0, 2, 0, 0, 0, 0, 0)); // beq released, from M
    add(1, mk( 0, 5, 0, 5, 1,31, 0, 0, 0), ex(0, 0, 0, 3, 0, 0, 0)); // jal
    add(1, mk(31, 0, 0, 5, 0, 0, 0, 0, 0), ex(0, 1, 0, 0, 0, 0, 0)); // jr $31 from E
    add(1, mk( 0, 5, 0, 5, 1, 0, 2, 0, 0), ex(0, 0, 0, 2, 0, 0, 0)); // write $0, Tnew 2
    add(1, mk( 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)); // read $0, Tuse 0
    add(1, mk( 0, 5, 0, 5, 1, 7, 1, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)); // ori $7
    add(1, mk( 0, 5, 0, 5, 1, 7, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)); // lui-like $7, Tnew 0
    add(1, mk( 7, 0, 0, 5, 0, 0, 0, 0, 0), ex(0, 1, 0, 0, 0, 0, 0)); // E beats M
    add(1, mk(29, 1, 0, 5, 1, 7, 2, 0, 0), ex(0, 0, 0, 2, 0, 0, 0)); // lw $7
    add(1, mk( 7, 2, 7, 5, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)); // E Tnew 2 blocks W
    add(1, nop,                            ex(0, 0, 0, 0, 0, 0, 0)); // M Tnew 1 blocks for E
    add(1, nop,                            ex(0, 0, 0, 0, 0, 3, 0)); // M.rt from W

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].d);
      cmp($sformatf("vec%0d", i), vq[i].e);
      advance();
    end

    // div then mflo: 11 stall cycles, 10 busy cycles
    drive(1'b1, mk(8, 1, 9, 1, 0, 0, 0, 2, 1));
    cmp("div_issue", z);
    advance();
    mflo = mk(0, 5, 0, 5, 1, 10, 1, 0, 1);
    n_stall = 0;
    n_busy  = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, mflo);
      chk($sformatf("mflo_stall%0d", i), int'(hif.stall), (i < 11) ? 1 : 0);
      chk($sformatf("mflo_busy%0d", i), int'(hif.md_busy), (i >= 1 && i <= 10) ? 1 : 0);
      n_stall += int'(hif.stall);
      n_busy  += int'(hif.md_busy);
      advance();
    end
    chk("div_stall_cycles", n_stall, 11);
    chk("div_busy_cycles", n_busy, 10);

    // mult abandoned by reset with counter at 3
    drive(1'b1, mk(8, 1, 9, 1, 0, 0, 0, 1, 1));
    chk("mult_issue.stall", int'(hif.stall), 0);
    advance();
    drive(1'b1, mk(1, 1, 1, 1, 1, 5, 1, 0, 0));
    chk("mult_e.busy", int'(hif.md_busy), 0);
    advance();
    drive(1'b1, mk(0, 5, 0, 5, 1, 31, 0, 0, 0));
    chk("mult_c5.busy", int'(hif.md_busy), 1);
    advance();
    drive(1'b1, nop);
    chk("mult_c4.busy", int'(hif.md_busy), 1);
    advance();
    drive(1'b0, mk(31, 0, 0, 5, 0, 0, 0, 0, 1));
    cmp("rst_hold", z);
    advance();
    drive(1'b1, mk(31, 0, 0, 5, 0, 0, 0, 0, 1));
    cmp("rst_after", z);
    advance();

    for (int i = 0; i < 600; i++) begin
      int r;
      d.rs   = 5'($urandom_range(0, 3));
      d.rt   = 5'($urandom_range(0, 3));
      d.tur  = 3'(tu[$urandom_range(0, 3)]);
      d.tut  = 3'(tu[$urandom_range(0, 3)]);
      d.rw   = 1'($urandom_range(0, 1));
      d.a3   = 5'($urandom_range(0, 3));
      d.tnew = 3'($urandom_range(0, 2));
      r      = int'($urandom_range(0, 15));
      d.mdop = (r == 0) ? 2'd1 : (r == 1) ? 2'd2 : 2'd0;
      d.use_md = ($urandom_range(0, 5) == 0);
      drive(($urandom_range(0, 39) != 0), d);
      cmp($sformatf("rnd%0d", i), m_expect());
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL provide: reset  in  1  synchronous, active-low; state cleared on a rising edge of clk while reset==0.
REQ-003 SHALL provide: D_rs, D_rt  in  5 each  source register numbers of the instruction in D.
REQ-004 SHALL provide: D_Tuse_rs, D_Tuse_rt  in  3 each  cycles until D needs the operand (0,1,2; 5 = not used).
REQ-005 SHALL provide: D_RegWrite  in  1, D_A3  in  5, D_Tnew  in  3  producer info of D; Tnew is counted from E entry (0,1,2).
REQ-006 SHALL provide: D_md_op  in  2  0 none, 1 mult, 2 div; D_md_use  in  1  D reads or writes HI/LO (incl. mult/div/mfhi/mflo/mthi/mtlo).
REQ-007 SHALL provide: stall  out  1  freeze PC and F/D, insert bubble into D/E.
REQ-008 SHALL provide: fwd_D_rs, fwd_D_rt  out  2 each  0 regfile, 1 from E, 2 from M, 3 from W.
REQ-009 SHALL provide: fwd_E_rs, fwd_E_rt  out  2 each  0 none, 2 from M, 3 from W; fwd_M_rt  out  2  0 none, 3 from W.
REQ-010 SHALL provide: md_busy  out  1  mult/div unit occupied.

Function
REQ-011 SHALL hold shadow stage records E, M, W, each {rs, rt, A3, RegWrite, Tnew}; E additionally holds md_op.
REQ-012 Each edge without stall: E<-D inputs; M<-E with Tnew=max(E.Tnew-1,0); W<-M with Tnew=max(M.Tnew-1,0).
REQ-013 Each edge with stall: E<-bubble (all fields 0); M<-E and W<-M as in REQ-012.
REQ-014 A stage "produces r" iff RegWrite==1, A3==r, r!=0; register 0 never causes stall or forward.
REQ-015 stall=1 if, for rs or rt with Tuse!=5, E produces it with E.Tnew>Tuse, or M produces it with M.Tnew>Tuse.
REQ-016 stall=1 if D_md_use==1 and (md_busy==1 or E.md_op!=0).
REQ-017 Stall conditions are ORed; stall is combinational from current state and D inputs.
REQ-018 fwd_D_x: nearest producing stage among E, M, W whose Tnew==0, priority E>M>W; else 0.
REQ-019 A nearer producer with Tnew!=0 SHALL block forwarding from farther stages (stall covers it).
REQ-020 fwd_E_x uses E.rs/E.rt against M then W; fwd_M_rt uses M.rt against W; same Tnew==0 and priority rules.
REQ-021 md counter (4 bit): on edge where E.md_op==1 load 5, ==2 load 10; else decrement if nonzero.
REQ-022 md_busy=1 iff counter!=0.
REQ-023 Counter load and decrement are mutually exclusive; load wins.

Reset
REQ-024 On reset edge: E, M, W = bubble, counter=0.
REQ-025 While reset==0: stall=0, all fwd_*=0, md_busy=0, regardless of D inputs.
REQ-026 Reset asserted mid-mult/div SHALL abandon the operation; md_busy=0 on the next cycle.

Verification
REQ-027 lw $2 (Tnew=2) in E, D addu reads $2 (Tuse=1) -> stall=1 one cycle; next cycle lw in M (Tnew=1), stall=0? no: M.Tnew=1==Tuse -> stall=0, fwd_D_rs=0; following cycle E.rs=$2 gets fwd_E_rs=3.
REQ-028 addu $3 (Tnew=1) in E, D beq reads $3 (Tuse=0) -> stall=1; next cycle M.Tnew=0 -> stall=0, fwd_D_rs=2.
REQ-029 jal (A3=31, Tnew=0) in E, D jr $31 (Tuse=0) -> stall=0, fwd_D_rs=1.
REQ-030 D writes $0 with Tnew=2, next D reads $0 with Tuse=0 -> stall=0, fwd_D_rs=0.
REQ-031 div enters E, then D mflo (md_use=1) -> stall=1 for 11 cycles (E cycle + 10 busy), md_busy high 10 cycles, released when counter reaches 0.
REQ-032 reset=0 for one edge during mult with counter=3 -> counter=0, stall=0, all fwd=0 after release.
